stall_control: RTL
==================

STALL_CONTROL -- requirements
Module: stall_control

Interface
REQ-001 SHALL have parameter DEPTH_W, default 8, nesting-depth counter width.
REQ-002 SHALL have parameter LIMIT_W, default 16, scan-cycle watchdog width.
REQ-003 SHALL have port clock, input, 1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port stall_start, input, 1: core control reports state == STALL_S this cycle.
REQ-006 SHALL have port stall_op, input, op_code: opcode that caused the stall.
REQ-007 SHALL have port instruction, input, op_code: opcode at the current PC during a scan.
REQ-008 SHALL have port busy, output, 1: stall sequence in progress.
REQ-009 SHALL have port done, output, 1: one-cycle pulse; core resumes CORE_S next cycle.
REQ-010 SHALL have port pc_write, output, 1: PC register write enable.
REQ-011 SHALL have port pc_src, output, pc_src_e: PC_INCREMENTED or PC_FROM_MEM.
REQ-012 SHALL have port loader_select, output, 1: 0 loads the low PC byte and 1 loads the high PC byte from memory.
REQ-013 SHALL have port cache_pop, output, 1: one-cycle pulse that decrements the cache (loop) stack pointer.
REQ-014 SHALL have port error, output, 1: sticky fault flag.

Function
REQ-015 SHALL implement the FSM states IDLE, POP_WAIT, SCAN_SKIP, SCAN, LOAD_LO and LOAD_HI.
REQ-016 In IDLE, SHALL go to POP_WAIT on stall_start with POP, to SCAN_SKIP with CBF, to LOAD_LO with CBB; any other stall_op SHALL set error and stay IDLE.
REQ-017 SHALL ignore stall_start while busy=1 and SHALL set error in that case.
REQ-018 POP_WAIT SHALL last 1 cycle with pc_write=1, pc_src=PC_INCREMENTED and done=1, then go to IDLE; total POP stall is 1 cycle.
REQ-019 SCAN_SKIP SHALL last 1 cycle with pc_write=1 and PC_INCREMENTED, SHALL ignore instruction (the CBF itself), SHALL clear depth and watchdog, and SHALL go to SCAN.
REQ-020 In each SCAN cycle, SHALL assert pc_write=1 with PC_INCREMENTED and SHALL increment the watchdog.
REQ-021 In SCAN, CBF SHALL cause depth+1.
REQ-022 In SCAN, CBB with depth>0 SHALL cause depth-1.
REQ-023 In SCAN, CBB with depth==0 SHALL assert done=1 and cache_pop=1 and SHALL go to IDLE, so the PC lands past the matching CBB.
REQ-024 In SCAN, any other opcode SHALL leave depth unchanged.
REQ-025 In SCAN, CBF at depth == 2^DEPTH_W-1 SHALL set error, assert done, and go to IDLE without wrapping depth.
REQ-026 When the watchdog reaches 2^LIMIT_W-1 in SCAN, SHALL set error, assert done, and go to IDLE; this covers an unmatched CBF or PC wrap.
REQ-027 LOAD_LO SHALL drive pc_write=1, pc_src=PC_FROM_MEM and loader_select=0, then go to LOAD_HI.
REQ-028 LOAD_HI SHALL drive pc_write=1, pc_src=PC_FROM_MEM, loader_select=1 and done=1, then go to IDLE; total CBB stall is 2 cycles.
REQ-029 In IDLE, SHALL drive pc_write=0, pc_src=PC_INCREMENTED, loader_select=0, busy=0, done=0 and cache_pop=0.
REQ-030 SHALL assert busy=1 in every state except IDLE.
REQ-031 SHALL make all outputs combinational from state and inputs, with no extra latency; depth and watchdog SHALL be registered.

Reset
REQ-032 While reset=1, SHALL go to IDLE, clear depth, watchdog and error, and drive all outputs to their IDLE values.
REQ-033 Reset mid-operation SHALL abort the sequence with no done or cache_pop pulse.

Structure
REQ-034 SHALL place stall_state_e, the pc_src_e value PC_FROM_MEM, and DEPTH_W/LIMIT_W defaults in the shared package definitions.
REQ-035 SHALL place the depth counter (inc/dec/clear, saturation detect) in sub-module scan_depth_counter.

Verification
REQ-036 Bench SHALL check: POP stall_start -> next cycle pc_write=1, done=1, busy=1; following cycle busy=0.
REQ-037 Bench SHALL check: CBF stall; instruction stream CBF,INC,CBB,DEC,CBB -> SCAN_SKIP plus 5 SCAN cycles, 6 pc_write pulses, done and cache_pop on the 2nd CBB only.
REQ-038 Bench SHALL check: CBB stall -> LOAD_LO (loader_select=0), then LOAD_HI (loader_select=1, done=1), with pc_src=PC_FROM_MEM both cycles.
REQ-039 Bench SHALL check: CBF stall with 255 nested CBF fed -> the 256th CBF sets error=1 and done=1, and depth does not wrap.
REQ-040 Bench SHALL check: CBF stall with only INC fed and LIMIT_W=4 -> done and error after 15 SCAN cycles.
REQ-041 Bench SHALL check: reset asserted in the 3rd SCAN cycle -> next cycle busy=0, error=0, and no done pulse.

Source files
------------

// File: rtl/stall_control_pkg.sv
// ----------------------------------------------------------------------------
// stall_control_pkg
// Shared definitions for the stall sequencer: opcode set, PC source select,
// FSM state encoding and default counter widths.
// ----------------------------------------------------------------------------
package stall_control_pkg;

    // Default widths for the nesting-depth counter and the scan watchdog.
    localparam int unsigned DEPTH_W_DEF = 8;
    localparam int unsigned LIMIT_W_DEF = 16;

    // Core instruction set as seen by the stall sequencer.
    typedef enum logic [3:0] {
        NOP = 4'd0,
        INC = 4'd1,
        DEC = 4'd2,
        MVL = 4'd3,
        MVR = 4'd4,
        RD  = 4'd5,
        WR  = 4'd6,
        CBF = 4'd7,
        CBB = 4'd8,
        POP = 4'd9
    } op_code;

    // Source of the next PC value.
    typedef enum logic {
        PC_INCREMENTED = 1'b0,
        PC_FROM_MEM    = 1'b1
    } pc_src_e;

    // Stall sequencer states.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_POP_WAIT  = 3'd1,
        S_SCAN_SKIP = 3'd2,
        S_SCAN      = 3'd3,
        S_LOAD_LO   = 3'd4,
        S_LOAD_HI   = 3'd5
    } stall_state_e;

    // True for the opcodes that legitimately put the core into a stall.
    function automatic logic starts_stall(input op_code op);
        return (op == POP) || (op == CBF) || (op == CBB);
    endfunction

endpackage

// File: rtl/stall_control_scan_depth.sv
// ----------------------------------------------------------------------------
// scan_depth_counter
// Loop nesting depth tracked while scanning forward for the CBB that matches
// a taken CBF. Saturates at both ends instead of wrapping.
//
// Ports:
//   clock    - rising-edge clock
//   reset    - synchronous active-high reset, clears depth
//   clear    - clear depth to zero (start of a scan)
//   inc      - nested CBF seen, depth + 1 (held at max)
//   dec      - inner CBB seen, depth - 1 (held at zero)
//   is_zero  - depth == 0
//   is_max   - depth == 2^DEPTH_W-1
// ----------------------------------------------------------------------------
module scan_depth_counter #(
    parameter int unsigned DEPTH_W = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    input  logic dec,
    output logic is_zero,
    output logic is_max
);

    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;

    always_comb begin
        is_zero = (depth_q == '0);
        is_max  = (depth_q == '1);
    end

    always_comb begin
        depth_d = depth_q;
        if (clear) begin
            depth_d = '0;
        end else if (inc && !is_max) begin
            depth_d = depth_q + 1'b1;
        end else if (dec && !is_zero) begin
            depth_d = depth_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/stall_control.sv
// ----------------------------------------------------------------------------
// stall_control
// Sequences the multi-cycle stalls of the core: POP (one PC increment), CBF
// (forward scan to the matching CBB) and CBB (two-byte PC reload from memory).
// Outputs are decoded combinationally from the current state and inputs.
//
// Ports:
//   clock         - rising-edge clock
//   reset         - synchronous active-high reset; outputs forced idle while high
//   stall_start   - core is in its stall state this cycle
//   stall_op      - opcode that caused the stall
//   instruction   - opcode at the current PC while scanning
//   busy          - stall sequence in progress
//   done          - one-cycle pulse, core resumes next cycle
//   pc_write      - PC register write enable
//   pc_src        - PC_INCREMENTED or PC_FROM_MEM
//   loader_select - 0: load low PC byte, 1: load high PC byte
//   cache_pop     - one-cycle pulse, pop the loop stack
//   error         - sticky fault flag
// ----------------------------------------------------------------------------
module stall_control
    import stall_control_pkg::*;
#(
    parameter int unsigned DEPTH_W = DEPTH_W_DEF,
    parameter int unsigned LIMIT_W = LIMIT_W_DEF
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    stall_start,
    input  op_code  stall_op,
    input  op_code  instruction,
    output logic    busy,
    output logic    done,
    output logic    pc_write,
    output pc_src_e pc_src,
    output logic    loader_select,
    output logic    cache_pop,
    output logic    error
);

    stall_state_e       state_q;
    stall_state_e       state_d;
    logic [LIMIT_W-1:0] watchdog_q;
    logic [LIMIT_W-1:0] watchdog_d;
    logic               error_q;
    logic               error_d;

    logic depth_clear;
    logic depth_inc;
    logic depth_dec;
    logic depth_zero;
    logic depth_max;

    scan_depth_counter #(
        .DEPTH_W (DEPTH_W)
    ) u_depth (
        .clock   (clock),
        .reset   (reset),
        .clear   (depth_clear),
        .inc     (depth_inc),
        .dec     (depth_dec),
        .is_zero (depth_zero),
        .is_max  (depth_max)
    );

    always_comb begin
        state_d       = state_q;
        watchdog_d    = watchdog_q;
        error_d       = error_q;
        busy          = 1'b0;
        done          = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_INCREMENTED;
        loader_select = 1'b0;
        cache_pop     = 1'b0;
        error         = error_q;
        depth_clear   = 1'b0;
        depth_inc     = 1'b0;
        depth_dec     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (stall_start) begin
                    case (stall_op)
                        POP:     state_d = S_POP_WAIT;
                        CBF:     state_d = S_SCAN_SKIP;
                        CBB:     state_d = S_LOAD_LO;
                        default: error_d = 1'b1;
                    endcase
                end
            end

            S_POP_WAIT: begin
                busy     = 1'b1;
                pc_write = 1'b1;
                done     = 1'b1;
                state_d  = S_IDLE;
            end

            // The PC still points at the CBF itself; step over it unread.
            S_SCAN_SKIP: begin
                busy        = 1'b1;
                pc_write    = 1'b1;
                depth_clear = 1'b1;
                watchdog_d  = '0;
                state_d     = S_SCAN;
            end

            // A matching CBB wins over the watchdog expiring in the same cycle.
            S_SCAN: begin
                busy       = 1'b1;
                pc_write   = 1'b1;
                watchdog_d = watchdog_q + 1'b1;
                if ((instruction == CBB) && depth_zero) begin
                    done      = 1'b1;
                    cache_pop = 1'b1;
                    state_d   = S_IDLE;
                end else if ((instruction == CBF) && depth_max) begin
                    error_d = 1'b1;
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else if (watchdog_d == '1) begin
                    error_d = 1'b1;
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    depth_inc = (instruction == CBF);
                    depth_dec = (instruction == CBB);
                end
            end

            S_LOAD_LO: begin
                busy          = 1'b1;
                pc_write      = 1'b1;
                pc_src        = PC_FROM_MEM;
                loader_select = 1'b0;
                state_d       = S_LOAD_HI;
            end

            S_LOAD_HI: begin
                busy          = 1'b1;
                pc_write      = 1'b1;
                pc_src        = PC_FROM_MEM;
                loader_select = 1'b1;
                done          = 1'b1;
                state_d       = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // A new stall request can only arrive while idle.
        if (busy && stall_start && !starts_stall(NOP)) begin
            error_d = 1'b1;
        end

        // Reset aborts the sequence immediately, suppressing done/cache_pop.
        if (reset) begin
            busy          = 1'b0;
            done          = 1'b0;
            pc_write      = 1'b0;
            pc_src        = PC_INCREMENTED;
            loader_select = 1'b0;
            cache_pop     = 1'b0;
            error         = 1'b0;
            depth_clear   = 1'b0;
            depth_inc     = 1'b0;
            depth_dec     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            watchdog_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            watchdog_q <= watchdog_d;
            error_q    <= error_d;
        end
    end

endmodule
